// File: rtl/instruction_sequencer.sv
// Instruction phase sequencer: fetches a word from instruction RAM with a
// ready handshake, steps it through FETCH/DECODE/EXECUTE/WRITEBACK, shortens
// the sequence for opcodes without writeback, and halts on 4'hF or on an
// undefined opcode. Presents the 2-bit phase and latched opcode to the
// control matrix.
module instruction_sequencer #(
  parameter int unsigned INSTR_WIDTH = 16,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   state_machine_reset,
  input  logic [INSTR_WIDTH-1:0] instruction,
  input  logic                   mem_ready,
  input  logic                   resume,
  output logic                   fetch_req,
  output logic [1:0]             state,
  output logic [3:0]             opcode,
  output logic [INSTR_WIDTH-5:0] operand,
  output logic                   halted,
  output logic                   illegal,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  typedef enum logic [2:0] {
    PH_FETCH     = 3'd0,
    PH_DECODE    = 3'd1,
    PH_EXECUTE   = 3'd2,
    PH_WRITEBACK = 3'd3,
    PH_HALT      = 3'd4
  } phase_t;

  localparam logic [3:0] OP_NOP    = 4'b0000;
  localparam logic [3:0] OP_STORE  = 4'b0011;
  localparam logic [3:0] OP_BRANCH = 4'b0110;
  localparam logic [3:0] OP_HALT   = 4'b1111;

  phase_t                 phase_q, phase_d;
  logic [1:0]             state_q, state_d;
  logic [3:0]             opcode_q;
  logic [INSTR_WIDTH-5:0] operand_q;
  logic                   halted_q;
  logic                   illegal_q;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   retire;
  logic                   set_illegal;
  logic                   accept;
  logic [3:0]             fetched_op;

  assign fetched_op = instruction[INSTR_WIDTH-1 -: 4];
  assign accept     = (phase_q == PH_FETCH) && mem_ready;

  // Next phase, retire strobe and illegal-opcode detection.
  always_comb begin
    phase_d     = phase_q;
    retire      = 1'b0;
    set_illegal = 1'b0;
    case (phase_q)
      PH_FETCH: begin
        if (mem_ready) begin
          if (fetched_op == OP_HALT) begin
            phase_d = PH_HALT;
            retire  = 1'b1;
          end else begin
            phase_d = PH_DECODE;
          end
        end
      end
      PH_DECODE: begin
        if (opcode_q == OP_NOP) begin
          phase_d = PH_FETCH;
          retire  = 1'b1;
        end else if (!opcode_q[3]) begin
          phase_d = PH_EXECUTE;
        end else begin
          // 4'hF never reaches DECODE, so any 1xxx here is undefined.
          phase_d     = PH_HALT;
          set_illegal = 1'b1;
        end
      end
      PH_EXECUTE: begin
        if (opcode_q == OP_STORE || opcode_q == OP_BRANCH) begin
          phase_d = PH_FETCH;
          retire  = 1'b1;
        end else begin
          phase_d = PH_WRITEBACK;
        end
      end
      PH_WRITEBACK: begin
        phase_d = PH_FETCH;
        retire  = 1'b1;
      end
      PH_HALT: begin
        if (resume) begin
          phase_d = PH_FETCH;
        end
      end
      default: phase_d = PH_FETCH;
    endcase
  end

  // Encoded phase for the control matrix (HALT reads as FETCH) and saturating count.
  always_comb begin
    state_d = 2'd0;
    case (phase_d)
      PH_DECODE:    state_d = 2'd1;
      PH_EXECUTE:   state_d = 2'd2;
      PH_WRITEBACK: state_d = 2'd3;
      default:      state_d = 2'd0;
    endcase
    count_d = count_q;
    if (retire && (count_q != '1)) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end
  end

  // Sequencer state and registered outputs; reset overrides all inputs.
  always_ff @(posedge clock) begin
    if (state_machine_reset) begin
      phase_q   <= PH_FETCH;
      state_q   <= 2'd0;
      opcode_q  <= '0;
      operand_q <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      phase_q  <= phase_d;
      state_q  <= state_d;
      halted_q <= (phase_d == PH_HALT);
      count_q  <= count_d;
      if (set_illegal) begin
        illegal_q <= 1'b1;
      end
      if (accept) begin
        opcode_q  <= fetched_op;
        operand_q <= instruction[INSTR_WIDTH-5:0];
      end
    end
  end

  assign fetch_req   = (phase_q == PH_FETCH) && !halted_q;
  assign state       = state_q;
  assign opcode      = opcode_q;
  assign operand     = operand_q;
  assign halted      = halted_q;
  assign illegal     = illegal_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer: a vector table walks the main
// phase sequences; hand sequences cover reset in HALT and count saturation.
module tb_instruction_sequencer;

  logic        clk;
  logic        rst, mr, res;
  logic [15:0] instr;
  logic        fr;
  logic [1:0]  st;
  logic [3:0]  op;
  logic [11:0] opd;
  logic        h, il;
  logic [15:0] cnt;

  logic        rst2, mr2, res2;
  logic [15:0] instr2;
  logic        fr2;
  logic [1:0]  st2;
  logic [3:0]  op2;
  logic [11:0] opd2;
  logic        h2, il2;
  logic [1:0]  cnt2;

  int checks;
  int failures;

  instruction_sequencer #(.INSTR_WIDTH(16), .COUNT_WIDTH(16)) dut (
    .clock(clk), .state_machine_reset(rst), .instruction(instr),
    .mem_ready(mr), .resume(res), .fetch_req(fr), .state(st),
    .opcode(op), .operand(opd), .halted(h), .illegal(il), .instr_count(cnt)
  );

  instruction_sequencer #(.INSTR_WIDTH(16), .COUNT_WIDTH(2)) dut_sat (
    .clock(clk), .state_machine_reset(rst2), .instruction(instr2),
    .mem_ready(mr2), .resume(res2), .fetch_req(fr2), .state(st2),
    .opcode(op2), .operand(opd2), .halted(h2), .illegal(il2), .instr_count(cnt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic        mr;
    logic        res;
    logic [15:0] instr;
    logic [1:0]  st;
    logic [3:0]  op;
    logic [11:0] opd;
    logic        h;
    logic        il;
    logic        fr;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic m, input logic rs, input logic [15:0] ins,
                     input logic [1:0] s, input logic [3:0] o, input logic [11:0] d,
                     input logic hh, input logic ii, input logic f, input logic [15:0] c);
    vec_t v;
    v.rst = r; v.mr = m; v.res = rs; v.instr = ins;
    v.st = s; v.op = o; v.opd = d; v.h = hh; v.il = ii; v.fr = f; v.cnt = c;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1; mr = 1'b0; res = 1'b0; instr = '0;
    rst2 = 1'b1; mr2 = 1'b0; res2 = 1'b0; instr2 = '0;

    //   rst mr res instr     st op    opd      h  il fr cnt
    add(1, 0, 0, 16'h0000, 0, 4'h0, 12'h000, 0, 0, 1, 0);  // reset
    add(0, 1, 0, 16'h1234, 1, 4'h1, 12'h234, 0, 0, 0, 0);  // full instruction
    add(0, 0, 0, 16'h0000, 2, 4'h1, 12'h234, 0, 0, 0, 0);
    add(0, 0, 0, 16'h0000, 3, 4'h1, 12'h234, 0, 0, 0, 0);
    add(0, 0, 0, 16'h0000, 0, 4'h1, 12'h234, 0, 0, 1, 1);
    add(0, 1, 0, 16'h3ABC, 1, 4'h3, 12'hABC, 0, 0, 0, 1);  // store
    add(0, 1, 0, 16'h6000, 2, 4'h3, 12'hABC, 0, 0, 0, 1);  // ready outside FETCH ignored
    add(0, 1, 0, 16'h6000, 0, 4'h3, 12'hABC, 0, 0, 1, 2);
    add(0, 1, 0, 16'h6000, 1, 4'h6, 12'h000, 0, 0, 0, 2);  // branch
    add(0, 1, 0, 16'h1111, 2, 4'h6, 12'h000, 0, 0, 0, 2);
    add(0, 0, 0, 16'h1111, 0, 4'h6, 12'h000, 0, 0, 1, 3);
    add(0, 0, 0, 16'h2222, 0, 4'h6, 12'h000, 0, 0, 1, 3);  // stall
    add(0, 0, 0, 16'h2222, 0, 4'h6, 12'h000, 0, 0, 1, 3);
    add(0, 0, 0, 16'h2222, 0, 4'h6, 12'h000, 0, 0, 1, 3);
    add(0, 1, 0, 16'h0000, 1, 4'h0, 12'h000, 0, 0, 0, 3);  // NOP
    add(0, 0, 0, 16'h0000, 0, 4'h0, 12'h000, 0, 0, 1, 4);
    add(0, 1, 0, 16'hF000, 0, 4'hF, 12'h000, 1, 0, 0, 5);  // halt, retires
    for (int k = 0; k < 5; k++)
      add(0, 1, 0, 16'h1234, 0, 4'hF, 12'h000, 1, 0, 0, 5);
    add(0, 0, 1, 16'h0000, 0, 4'hF, 12'h000, 0, 0, 1, 5);  // resume
    add(0, 1, 0, 16'h9000, 1, 4'h9, 12'h000, 0, 0, 0, 5);  // undefined
    add(0, 0, 0, 16'h0000, 0, 4'h9, 12'h000, 1, 1, 0, 5);
    add(0, 0, 1, 16'h0000, 0, 4'h9, 12'h000, 0, 1, 1, 5);  // illegal sticky
    add(0, 1, 0, 16'h7ABC, 1, 4'h7, 12'hABC, 0, 1, 0, 5);
    add(0, 0, 0, 16'h0000, 2, 4'h7, 12'hABC, 0, 1, 0, 5);
    add(1, 1, 1, 16'h3555, 0, 4'h0, 12'h000, 0, 0, 1, 0);  // reset in EXECUTE
    add(0, 0, 1, 16'h0000, 0, 4'h0, 12'h000, 0, 0, 1, 0);  // resume outside HALT

    step();
    foreach (vecs[i]) begin
      rst = vecs[i].rst; mr = vecs[i].mr; res = vecs[i].res; instr = vecs[i].instr;
      step();
      check($sformatf("v%0d.state", i),       32'(st),  32'(vecs[i].st));
      check($sformatf("v%0d.opcode", i),      32'(op),  32'(vecs[i].op));
      check($sformatf("v%0d.operand", i),     32'(opd), 32'(vecs[i].opd));
      check($sformatf("v%0d.halted", i),      32'(h),   32'(vecs[i].h));
      check($sformatf("v%0d.illegal", i),     32'(il),  32'(vecs[i].il));
      check($sformatf("v%0d.fetch_req", i),   32'(fr),  32'(vecs[i].fr));
      check($sformatf("v%0d.instr_count", i), 32'(cnt), 32'(vecs[i].cnt));
    end

    // Reset while halted.
    rst = 1'b0; res = 1'b0; mr = 1'b1; instr = 16'hF123;
    step();
    check("halt_entry.halted", 32'(h), 32'd1);
    check("halt_entry.count", 32'(cnt), 32'd1);
    rst = 1'b1; res = 1'b1;
    step();
    check("halt_reset.halted", 32'(h), 32'd0);
    check("halt_reset.count", 32'(cnt), 32'd0);
    check("halt_reset.opcode", 32'(op), 32'd0);
    check("halt_reset.fetch_req", 32'(fr), 32'd1);
    rst = 1'b0; res = 1'b0; mr = 1'b0;

    // Saturating 2-bit counter with back-to-back NOPs.
    rst2 = 1'b0; mr2 = 1'b1; instr2 = 16'h0000;
    for (int k = 1; k <= 5; k++) begin
      step();
      check($sformatf("sat%0d.decode", k), 32'(st2), 32'd1);
      step();
      check($sformatf("sat%0d.state", k), 32'(st2), 32'd0);
      check($sformatf("sat%0d.count", k), 32'(cnt2), (k > 3) ? 32'd3 : 32'(k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
